// File: rtl/a2d_spi_responder.sv
// SPI slave modelling an 8-channel, 12-bit A2D converter: each 16-bit frame replies
// with the conversion for the channel selected by the previous complete command.
module a2d_spi_responder #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [95:0] chan_data,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  output logic        cmd_vld,
  output logic [15:0] last_cmd,
  output logic        frame_err
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
  localparam logic [1:0] FINISH = 2'd2;

  logic [SYNC_STAGES-1:0] ss_q, sclk_q, mosi_q;
  logic                   ss_d, sclk_d;
  logic                   ss_s, sclk_s, mosi_s;
  logic                   ss_fall, ss_rise, sclk_fall, sclk_rise;

  logic [1:0]  state;
  logic [15:0] tx_shreg, rx_shreg;
  logic [4:0]  bit_cnt;
  logic [2:0]  ptr;
  logic        fall_pend;
  logic [11:0] chan [8];

  for (genvar g = 0; g < 8; g++) begin : g_chan
    assign chan[g] = chan_data[12*g +: 12];
  end

  // NOTE: the synchronizers and edge-detect flops are deliberately left out of reset:
  // they keep tracking the pins, so a master holding SS_n low across reset does not
  // look like a fresh SS_n fall when reset releases.
  always_ff @(posedge clk) begin
    ss_q   <= {ss_q[SYNC_STAGES-2:0], SS_n};
    sclk_q <= {sclk_q[SYNC_STAGES-2:0], SCLK};
    mosi_q <= {mosi_q[SYNC_STAGES-2:0], MOSI};
    ss_d   <= ss_s;
    sclk_d <= sclk_s;
  end

  assign ss_s      = ss_q[SYNC_STAGES-1];
  assign sclk_s    = sclk_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_q[SYNC_STAGES-1];
  assign ss_fall   = ss_d & ~ss_s;
  assign ss_rise   = ~ss_d & ss_s;
  assign sclk_fall = sclk_d & ~sclk_s;
  assign sclk_rise = ~sclk_d & sclk_s;

  assign MISO = ~ss_s & tx_shreg[15];

  // NOTE: all state updates use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tx_shreg  <= '0;
      rx_shreg  <= '0;
      bit_cnt   <= '0;
      ptr       <= '0;
      last_cmd  <= '0;
      cmd_vld   <= 1'b0;
      frame_err <= 1'b0;
      fall_pend <= 1'b0;
    end else begin
      cmd_vld   <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (ss_fall || fall_pend) begin
            tx_shreg  <= {4'h0, chan[ptr]};
            rx_shreg  <= '0;
            bit_cnt   <= '0;
            fall_pend <= 1'b0;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          // SS_n rise takes priority: a coincident SCLK edge belongs to no bit.
          if (ss_rise) begin
            state <= FINISH;
          end else if (sclk_rise) begin
            rx_shreg <= {rx_shreg[14:0], mosi_s};
            if (bit_cnt != 5'd31) bit_cnt <= bit_cnt + 5'd1;
          end else if (sclk_fall && bit_cnt != 5'd0) begin
            tx_shreg <= {tx_shreg[14:0], 1'b0};
          end
        end
        FINISH: begin
          if (bit_cnt == 5'd16) begin
            ptr      <= rx_shreg[13:11];
            last_cmd <= rx_shreg;
            cmd_vld  <= 1'b1;
          end else begin
            frame_err <= 1'b1;
          end
          if (ss_fall) fall_pend <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_a2d_spi_responder.sv
// Self-checking bench for a2d_spi_responder: plays an SPI mode-3 master and compares
// replies and pulses against a channel-pointer model of the A2D converter.
module tb_a2d_spi_responder;

  localparam int S    = 2;
  localparam int HALF = S + 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [95:0] chan_data;
  logic        SS_n, SCLK, MOSI;
  logic        MISO, cmd_vld, frame_err;
  logic [15:0] last_cmd;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: the channel the next reply will come from, and the last good command.
  logic [2:0]  ptr_m;
  logic [15:0] last_cmd_m;
  logic [15:0] exp_reply;
  logic [15:0] reply;

  always #10 clk = ~clk;

  a2d_spi_responder #(.SYNC_STAGES(S)) dut (
    .clk       (clk),
    .rst       (rst),
    .chan_data (chan_data),
    .SS_n      (SS_n),
    .SCLK      (SCLK),
    .MOSI      (MOSI),
    .MISO      (MISO),
    .cmd_vld   (cmd_vld),
    .last_cmd  (last_cmd),
    .frame_err (frame_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_chan(input int k, input logic [11:0] v);
    chan_data[12*k +: 12] = v;
  endtask

  task automatic frame_start();
    @(negedge clk);
    SS_n = 1'b0;
    exp_reply = {4'h0, chan_data[12*int'(ptr_m) +: 12]};
    wait_neg(HALF);
  endtask

  // Master drives on SCLK fall, samples MISO just before raising SCLK.
  task automatic send_bits(input logic [15:0] cmd, input int nbits, output logic [15:0] rep);
    rep = '0;
    for (int i = 0; i < nbits; i++) begin
      SCLK = 1'b0;
      MOSI = cmd[15-i];
      wait_neg(HALF);
      rep[15-i] = MISO;
      SCLK = 1'b1;
      wait_neg(HALF);
    end
  endtask

  task automatic frame_end(input bit full, input logic [15:0] cmd);
    logic [7:0] vld_seen, err_seen, one_hot;
    vld_seen = '0;
    err_seen = '0;
    one_hot  = 8'h01 << (S + 1);
    SS_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      vld_seen[k] = cmd_vld;
      err_seen[k] = frame_err;
    end
    check("cmd_vld timing", {24'h0, vld_seen}, full ? {24'h0, one_hot} : 32'h0);
    check("frame_err timing", {24'h0, err_seen}, full ? 32'h0 : {24'h0, one_hot});
    if (full) begin
      ptr_m      = cmd[13:11];
      last_cmd_m = cmd;
    end
    check("last_cmd", {16'h0, last_cmd}, {16'h0, last_cmd_m});
  endtask

  task automatic full_frame(input logic [15:0] cmd, input string tag);
    frame_start();
    send_bits(cmd, 16, reply);
    check(tag, {16'h0, reply}, {16'h0, exp_reply});
    frame_end(1'b1, cmd);
  endtask

  initial begin
    rst  = 1'b1;
    SS_n = 1'b1;
    SCLK = 1'b1;
    MOSI = 1'b0;
    chan_data = {$urandom, $urandom, $urandom};
    set_chan(0, 12'hABC);
    ptr_m      = 3'd0;
    last_cmd_m = 16'h0000;
    wait_neg(6);
    rst = 1'b0;
    wait_neg(1);
    check("reset MISO", {31'h0, MISO}, 32'h0);
    check("reset cmd_vld", {31'h0, cmd_vld}, 32'h0);
    check("reset frame_err", {31'h0, frame_err}, 32'h0);
    check("reset last_cmd", {16'h0, last_cmd}, 32'h0);

    // Power-up read of channel 0, then the channel-4 reply the command asked for.
    full_frame(16'h2000, "power-up reply");
    check("power-up literal", {16'h0, reply}, 32'h0ABC);
    full_frame(16'h0000, "ch4 after power-up");

    // Round robin pairs over channels 0, 4, 5.
    set_chan(0, 12'h123);
    set_chan(4, 12'h456);
    set_chan(5, 12'hFFF);
    full_frame(16'h0000, "rr set ch0");
    full_frame(16'h2000, "rr ch0");
    check("rr ch0 literal", {16'h0, reply}, 32'h0123);
    full_frame(16'h2000, "rr ch4");
    check("rr ch4 literal", {16'h0, reply}, 32'h0456);
    full_frame(16'h2800, "rr pre ch5");
    full_frame(16'h2800, "rr ch5");
    check("rr ch5 literal", {16'h0, reply}, 32'h0FFF);

    // Aborted 9-bit frame addressing ch7: pointer must stay on ch5.
    frame_start();
    send_bits(16'h3800, 9, reply);
    frame_end(1'b0, 16'h3800);
    full_frame(16'h0000, "after abort");
    check("after abort literal", {16'h0, reply}, 32'h0FFF);

    // Snapshot: ch5 changes mid-frame, reply keeps the value seen at SS_n fall.
    set_chan(5, 12'h555);
    full_frame(16'h2800, "snap setup");
    frame_start();
    fork
      send_bits(16'h2800, 16, reply);
      begin
        wait_neg(HALF * 8);
        set_chan(5, 12'hAAA);
      end
    join
    check("snapshot reply", {16'h0, reply}, 32'h0555);
    frame_end(1'b1, 16'h2800);
    full_frame(16'h2800, "post-snapshot");
    check("post-snapshot literal", {16'h0, reply}, 32'h0AAA);

    // Reset at bit 8 with ptr = 5: no pulses, MISO low, next frame reads ch0.
    frame_start();
    send_bits(16'h3800, 8, reply);
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_neg(1);
      check("rst MISO", {31'h0, MISO}, 32'h0);
      check("rst pulses", {30'h0, cmd_vld, frame_err}, 32'h0);
    end
    rst        = 1'b0;
    ptr_m      = 3'd0;
    last_cmd_m = 16'h0000;
    for (int k = 0; k < 8; k++) begin
      wait_neg(1);
      check("post-rst MISO", {31'h0, MISO}, 32'h0);
      check("post-rst pulses", {30'h0, cmd_vld, frame_err}, 32'h0);
    end
    SS_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      wait_neg(1);
      check("post-rst release pulses", {30'h0, cmd_vld, frame_err}, 32'h0);
    end
    check("post-rst last_cmd", {16'h0, last_cmd}, 32'h0);
    full_frame(16'h1800, "post-rst ch0");
    check("post-rst ch0 literal", {16'h0, reply}, {20'h0, chan_data[11:0]});

    // Minimum SCLK spacing with random commands and channel values.
    for (int f = 0; f < 300; f++) begin
      chan_data = {$urandom, $urandom, $urandom};
      full_frame(16'($urandom), "random reply");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
